cb_addr_decode: RTL and testbench

- Inverse of the covariance-block (CB) address generator. Given a packed CB word address and the row's bank index, it recovers the (row, col) coordinate that produced that address.
- Used by the CB scrub/readback path and by debug dump logic, which see only bank and address.
- Iterative group search (one group per cycle) followed by one offset/column resolve cycle.
- Valid/ready request in, valid/ready response out.

---
 rtl/cb_pkg.sv | 28 ++
 rtl/cb_grp_offset.sv | 23 ++
 rtl/cb_addr_decode.sv | 134 +++++++++++++
 tb/tb_cb_addr_decode.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// Shared constants and address-map helpers for the covariance-block (CB) address encoder/decoder pair.
// G(k) is the group base address; O(k,i) is the in-group offset of bank i.
package cb_pkg;

  localparam int CB_AW         = 17;
  localparam int MAX_LANDMARK  = 500;
  localparam int ROW_LEN       = 10;
  localparam int NUM_STATE_ROW = 2 * MAX_LANDMARK + 3;
  localparam int NUM_GROUP     = (NUM_STATE_ROW + 7) / 8;
  localparam int KW            = ROW_LEN - 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_CALC   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  function automatic logic [CB_AW-1:0] grp_base(input int k);
    return CB_AW'(8 * k * k + k);
  endfunction

  function automatic logic [ROW_LEN-1:0] grp_offset(input int k, input int i);
    return (i < 4) ? '0 : ROW_LEN'(8 * k + 8 - i);
  endfunction

  // First address past the last group; anything at or above it is illegal.
  localparam logic [CB_AW-1:0] ADDR_LIMIT = grp_base(NUM_GROUP);

endpackage

// File: rtl/cb_grp_offset.sv
// Combinational in-group offset O(k,i): zero for banks 0-3, 8k + 8 - i for banks 4-7.
module cb_grp_offset
  import cb_pkg::*;
(
  input  logic [KW-1:0]      grp_k,
  input  logic [2:0]         bank,
  output logic [ROW_LEN-1:0] offset
);

  logic [ROW_LEN-1:0] grp_x8;

  always_comb begin
    grp_x8 = {grp_k, 3'b000};
    case (bank)
      3'd4:    offset = grp_x8 + ROW_LEN'(4);
      3'd5:    offset = grp_x8 + ROW_LEN'(3);
      3'd6:    offset = grp_x8 + ROW_LEN'(2);
      3'd7:    offset = grp_x8 + ROW_LEN'(1);
      default: offset = '0;
    endcase
  end

endmodule

// File: rtl/cb_addr_decode.sv
// Inverse CB address map: recovers (row, col) from a packed CB address and bank by
// walking groups one per cycle, then resolving offset/column in a single cycle.
module cb_addr_decode
  import cb_pkg::*;
(
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CB_AW-1:0]   req_addr,
  input  logic [2:0]         req_bank,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ROW_LEN-1:0] rsp_row,
  output logic [ROW_LEN-1:0] rsp_col,
  output logic               rsp_err,
  output logic [1:0]         dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // rsp_* stay stable while rsp_valid is high and not yet accepted.

  logic [1:0]         state_q, state_d;
  logic [CB_AW-1:0]   addr_q, addr_d;
  logic [2:0]         bank_q, bank_d;
  logic [KW-1:0]      k_q, k_d;
  logic [CB_AW-1:0]   base_q, base_d;
  logic [CB_AW-1:0]   step_q, step_d;
  logic [ROW_LEN-1:0] row_q, row_d;
  logic [ROW_LEN-1:0] col_q, col_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;

  logic [CB_AW:0]     nxt;
  logic [ROW_LEN-1:0] grp_off;
  logic [ROW_LEN-1:0] row_calc;
  logic [CB_AW:0]     col_diff;
  logic               col_neg;
  logic               col_over;

  cb_grp_offset u_grp_offset (
    .grp_k  (k_q),
    .bank   (bank_q),
    .offset (grp_off)
  );

  // One extra bit on nxt and col_diff so neither the search compare nor the underflow test can wrap.
  assign nxt      = {1'b0, base_q} + {1'b0, step_q};
  assign row_calc = {k_q, bank_q};
  assign col_diff = {1'b0, addr_q} - {1'b0, base_q} - (CB_AW+1)'(grp_off);
  assign col_neg  = col_diff[CB_AW];
  assign col_over = !col_neg && (col_diff > (CB_AW+1)'(row_calc));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    k_d     = k_q;
    base_d  = base_q;
    step_d  = step_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = err_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          bank_d  = req_bank;
          k_d     = '0;
          base_d  = '0;
          step_d  = CB_AW'(9);
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if ((nxt <= {1'b0, addr_q}) && (k_q < KW'(NUM_GROUP - 1))) begin
          k_d    = k_q + KW'(1);
          base_d = nxt[CB_AW-1:0];
          step_d = step_q + CB_AW'(16);
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        row_d   = row_calc;
        col_d   = col_diff[ROW_LEN-1:0];
        err_d   = col_neg || col_over || (addr_q >= ADDR_LIMIT);
        valid_d = 1'b1;
        state_d = ST_RESP;
      end
      default: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      bank_q  <= '0;
      k_q     <= '0;
      base_q  <= '0;
      step_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      k_q     <= k_d;
      base_q  <= base_d;
      step_q  <= step_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = valid_q;
  assign rsp_row   = row_q;
  assign rsp_col   = col_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cb_addr_decode.sv
// Bench for cb_addr_decode: directed boundary cases, handshake/reset scenarios and
// randomized requests scored against an integer model of the CB address map.
module tb_cb_addr_decode;

  localparam int NGRP  = (2 * 500 + 3 + 7) / 8;
  localparam int LIMIT = 8 * NGRP * NGRP + NGRP;

  logic        clk;
  logic        sys_rst;
  logic        req_valid;
  logic        req_ready;
  logic [16:0] req_addr;
  logic [2:0]  req_bank;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [9:0]  rsp_row;
  logic [9:0]  rsp_col;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_errors;

  // {err, row[9:0], col[9:0], latency[7:0]}
  logic [28:0] exp_q[$];

  cb_addr_decode dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_bank  (req_bank),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_row   (rsp_row),
    .rsp_col   (rsp_col),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: largest group whose base is <= addr (capped), then column from base and offset.
  function automatic void ref_decode(input int addr, input int bank, output int k,
                                     output bit err, output int row, output int col);
    k = 0;
    while (k < NGRP - 1 && (8 * (k + 1) * (k + 1) + (k + 1)) <= addr) k++;
    row = 8 * k + bank;
    col = addr - (8 * k * k + k) - ((bank < 4) ? 0 : (8 * k + 8 - bank));
    err = (col < 0) || (col > row) || (addr >= LIMIT);
  endfunction

  task automatic push_exp(input int addr, input int bank);
    int k, row, col;
    bit err;
    logic [7:0] lat;
    ref_decode(addr, bank, k, err, row, col);
    lat = 8'(k + 2);
    exp_q.push_back({err, row[9:0], col[9:0], lat});
  endtask

  // Counts edges after the accept edge until rsp_valid appears, then scores the response.
  task automatic wait_and_score(input string tag);
    int cyc;
    logic [28:0] e;
    cyc = 0;
    while (!rsp_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = exp_q.pop_front();
    if (!rsp_valid) begin
      chk({tag, "_timeout"}, 32'(rsp_valid), 32'd1);
    end else begin
      chk({tag, "_lat"}, 32'(cyc), 32'(e[7:0]));
      chk({tag, "_err"}, 32'(rsp_err), 32'(e[28]));
      if (!e[28]) begin
        chk({tag, "_row"}, 32'(rsp_row), 32'(e[27:18]));
        chk({tag, "_col"}, 32'(rsp_col), 32'(e[17:8]));
      end
    end
  endtask

  task automatic accept_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic send_req(input int addr, input int bank);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    push_exp(addr, bank);
    req_addr  = addr[16:0];
    req_bank  = bank[2:0];
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input int addr, input int bank, input string tag);
    send_req(addr, bank);
    wait_and_score(tag);
    if (rsp_valid) accept_rsp(tag);
  endtask

  int dir_addr [9] = '{0, 24, 8, 126124, 127134, 5, 9, 127133, 131071};
  int dir_bank [9] = '{3, 4, 7, 0, 5, 1, 5, 7, 7};

  initial begin
    int row, col, k, addr, bank;
    bit saw;
    n_checks  = 0;
    n_errors  = 0;
    sys_rst   = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_bank  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_row", 32'(rsp_row), 32'd0);
    chk("rst_rsp_col", 32'(rsp_col), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Directed boundaries
    for (int i = 0; i < 9; i++) run_txn(dir_addr[i], dir_bank[i], $sformatf("dir%0d", i));

    // Hold the response for 10 cycles while a second request is pending
    send_req(24, 4);
    wait_and_score("hold");
    req_addr  = 17'd0;
    req_bank  = 3'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_row", 32'(rsp_row), 32'd12);
      chk("hold_col", 32'(rsp_col), 32'd3);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hold_release_valid", 32'(rsp_valid), 32'd0);
    chk("hold_release_ready", 32'(req_ready), 32'd1);
    push_exp(0, 3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("next_accept", 32'(req_ready), 32'd0);
    wait_and_score("next");
    if (rsp_valid) accept_rsp("next");

    // Reset during a long search aborts it with no response
    send_req(126124, 0);
    void'(exp_q.pop_front());
    repeat (20) @(posedge clk);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_row", 32'(rsp_row), 32'd0);
    chk("mid_rst_col", 32'(rsp_col), 32'd0);
    chk("mid_rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1'b1;
    end
    chk("no_stale_rsp", 32'(saw), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Randomized legal coordinates through the forward map
    for (int i = 0; i < 25; i++) begin
      row  = $urandom_range(0, 1007);
      col  = $urandom_range(0, row);
      k    = row / 8;
      bank = row % 8;
      addr = 8 * k * k + k + ((bank < 4) ? 0 : (8 * k + 8 - bank)) + col;
      run_txn(addr, bank, "fwd");
    end

    // Randomized raw addresses, including the tail near the end of the map
    for (int i = 0; i < 25; i++) begin
      if (i % 5 == 0) addr = $urandom_range(LIMIT - 2100, 131071);
      else            addr = $urandom_range(0, 131071);
      bank = $urandom_range(0, 7);
      run_txn(addr, bank, "raw");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
